// File: rtl/viterbi_pkg.sv
// viterbi_pkg: shared trellis types, FSM encoding and predecessor helper for the traceback unit
package viterbi_pkg;
  localparam int MAX_M = 16;
  typedef logic [MAX_M-1:0] state_t;
  typedef enum logic [1:0] {IDLE, TRACE, DONE} fsm_e;
  function automatic int calc_m(input int k);
    return k - 1;
  endfunction
  function automatic int calc_ns(input int k);
    return 1 << (k - 1);
  endfunction
  // predecessor = {s[m-2:0], d}, masked to m bits so upper bits stay zero
  function automatic state_t prev_state(input state_t s, input logic d, input int m);
    return ((s << 1) | state_t'(d)) & ((state_t'(1) << m) - state_t'(1));
  endfunction
endpackage

// File: rtl/viterbi_surv_mem.sv
// viterbi_surv_mem: D x NS survivor ring, one write port and a combinational single-bit read port
module viterbi_surv_mem #(
  parameter int D = 60,
  parameter int NS = 256,
  parameter int AW = 6,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [NS-1:0] wd,
  input  logic [AW-1:0] ra,
  input  logic [SW-1:0] rs,
  output logic          rd
);
  logic [NS-1:0] mem_q [D];
  always_ff @(posedge clk)
    if (we) mem_q[wa] <= wd;
  assign rd = mem_q[ra][rs];
endmodule

// File: rtl/viterbi_traceback_blk.sv
// viterbi_traceback_blk: survivor ring plus traceback emitting BLK_LEN-bit blocks.
// Optional TB_TERM_EN adds i_term: zero start state on terminated frames and threshold reload.
module viterbi_traceback_blk
  import viterbi_pkg::*;
#(
  parameter int K = 9,
  parameter int BLK_LEN = 20,
  parameter int TB_DEPTH = 40,
  localparam int M = calc_m(K),
  localparam int NS = calc_ns(K),
  localparam int D = TB_DEPTH + BLK_LEN,
  localparam int PW = $clog2(D),
  localparam int FW = $clog2(D + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_dec_vld,
  input  logic [NS-1:0]      i_dec,
  input  logic [M-1:0]       i_sel_node,
`ifdef TB_TERM_EN
  input  logic               i_term,
`endif
  output logic               o_rdy,
  output logic [BLK_LEN-1:0] o_data,
  output logic               o_done
);
  fsm_e fsm_q, fsm_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, step_q, step_d;
  logic [FW-1:0] fresh_q, fresh_d, fresh_inc, thr;
  logic first_q, first_d, rdy_q, rdy_d, done_q, done_d;
  logic acc, trig, tracing, rd_bit, term;
  state_t s_q, s_d, start, nxt;
  logic [BLK_LEN-1:0] shadow_q, shadow_d, data_q, data_d;
`ifdef TB_TERM_EN
  assign term = i_term;
`else
  assign term = 1'b0;
`endif
  viterbi_surv_mem #(.D(D), .NS(NS), .AW(PW), .SW(M)) u_mem (
    .clk(clk),
    .we(acc),
    .wa(wr_ptr_q),
    .wd(i_dec),
    .ra(rd_ptr_q),
    .rs(s_q[M-1:0]),
    .rd(rd_bit)
  );
  always_comb begin
    acc = i_dec_vld & rdy_q;
    thr = first_q ? FW'(D) : FW'(BLK_LEN);
    fresh_inc = fresh_q + FW'(1);
    trig = acc & (fresh_inc == thr);
    tracing = fsm_q == TRACE;
    start = term ? '0 : state_t'(i_sel_node);
    nxt = prev_state(s_q, rd_bit, M);
    wr_ptr_d = !acc ? wr_ptr_q : wr_ptr_q == PW'(D - 1) ? '0 : wr_ptr_q + PW'(1);
    rd_ptr_d = trig ? wr_ptr_q : !tracing ? rd_ptr_q : rd_ptr_q == '0 ? PW'(D - 1) : rd_ptr_q - PW'(1);
    fresh_d = trig ? '0 : acc ? fresh_inc : fresh_q;
    first_d = trig ? term : first_q;
    step_d = tracing ? step_q + PW'(1) : '0;
    s_d = trig ? start : tracing ? nxt : s_q;
    // left shift: the first kept bit (latest in time) lands at index BLK_LEN-1
    shadow_d = tracing && step_q >= PW'(TB_DEPTH) ? BLK_LEN'({shadow_q, s_q[M-1]}) : shadow_q;
    fsm_d = fsm_q == IDLE ? (trig ? TRACE : IDLE)
          : fsm_q == TRACE ? (step_q == PW'(D - 1) ? DONE : TRACE)
          : IDLE;
    rdy_d = fsm_d == IDLE;
    done_d = fsm_q == DONE;
    data_d = done_d ? shadow_q : data_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      step_q <= '0;
      fresh_q <= '0;
      first_q <= 1'b1;
      rdy_q <= 1'b0;
      done_q <= 1'b0;
      s_q <= '0;
      shadow_q <= '0;
      data_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      step_q <= step_d;
      fresh_q <= fresh_d;
      first_q <= first_d;
      rdy_q <= rdy_d;
      done_q <= done_d;
      s_q <= s_d;
      shadow_q <= shadow_d;
      data_q <= data_d;
    end
  end
  assign o_rdy = rdy_q;
  assign o_data = data_q;
  assign o_done = done_q;
endmodule

// File: tb/tb_viterbi_traceback_blk.sv
// tb_viterbi_traceback_blk: randomized scoreboard bench for the traceback unit (K=3, BLK_LEN=4, TB_DEPTH=4)
module tb_viterbi_traceback_blk;
  localparam int K = 3, BL = 4, TD = 4, M = 2, NS = 4, D = TD + BL;
  typedef struct {logic [BL-1:0] data; int trig;} exp_t;
  logic clk = 1'b0, rst = 1'b0, vld = 1'b0, term = 1'b0;
  logic o_rdy, o_done;
  logic [NS-1:0] dec = '0;
  logic [M-1:0] sel = '0, ts = '0;
  logic [BL-1:0] o_data;
  int checks = 0, errors = 0, cyc = 0, fresh_m = 0;
  bit first_m = 1'b1, ideal = 1'b1;
  exp_t sb[$];
  exp_t mon_e;
  logic [BL-1:0] got[$];
  logic [NS-1:0] hist[$];
  int bits[$];

  viterbi_traceback_blk #(.K(K), .BLK_LEN(BL), .TB_DEPTH(TD)) dut (
    .clk(clk),
    .rst(rst),
    .i_dec_vld(vld),
    .i_dec(dec),
    .i_sel_node(sel),
`ifdef TB_TERM_EN
    .i_term(term),
`endif
    .o_rdy(o_rdy),
    .o_data(o_data),
    .o_done(o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected the run to finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got_v, exp_v);
    end
  endtask

  // Walk the accepted decision history backwards from the newest vector
  function automatic logic [BL-1:0] trace_model(input int start);
    int s, n;
    logic [NS-1:0] v;
    logic [BL-1:0] r;
    s = start;
    n = hist.size();
    r = '0;
    for (int k = 0; k < D; k++) begin
      v = hist[n-1-k];
      if (k >= TD) r[BL-1-(k-TD)] = 1'((s >> (M - 1)) & 1);
      s = ((s << 1) | int'(v[s])) & (NS - 1);
    end
    return r;
  endfunction

  // Ideal decisions: the block is simply the encoder input bits in the window
  function automatic logic [BL-1:0] bits_model();
    int base;
    logic [BL-1:0] r;
    base = bits.size() - D;
    for (int i = 0; i < BL; i++) r[i] = bits[base+i] != 0;
    return r;
  endfunction

  task automatic send(input logic [NS-1:0] v, input logic [M-1:0] s, input bit t, output int n);
    int st;
    logic [BL-1:0] e;
    n = 0;
    @(negedge clk);
    dec = v; sel = s; term = t; vld = 1'b1;
    while (!o_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_rdy) begin
      checks++; errors++;
      $display("FAIL accept_timeout: o_rdy=%0b, expected 1", o_rdy);
      vld = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    vld = 1'b0; term = 1'b0;
    hist.push_back(v);
    fresh_m++;
    if (fresh_m == (first_m ? D : BL)) begin
      st = s;
`ifdef TB_TERM_EN
      if (t) st = 0;
`endif
      e = ideal ? bits_model() : trace_model(st);
      sb.push_back(exp_t'{data: e, trig: cyc});
      fresh_m = 0;
      first_m = 1'b0;
`ifdef TB_TERM_EN
      first_m = t;
`endif
    end
  endtask

  task automatic send_bit(input int b, output int n);
    logic [M-1:0] prev;
    logic [NS-1:0] v;
    prev = ts;
    ts = {b[0], prev[M-1:1]};
    v = NS'($urandom);
    v[ts] = prev[0];
    bits.push_back(b);
    send(v, ts, 1'b0, n);
  endtask

  task automatic send_rand();
    int n;
    bits.push_back(0);
    send(NS'($urandom), M'($urandom), 1'b0, n);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst && o_done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: o_done=1 data=%b, expected no block", o_data);
      end else begin
        mon_e = sb.pop_front();
        chk("block_data", o_data, mon_e.data);
        chk("block_latency", cyc - mon_e.trig, D + 1);
        got.push_back(o_data);
      end
    end
  end

  initial begin
    int n, left;
    int pat[12] = '{1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 0, 1};
    repeat (3) @(negedge clk);
    chk("reset_rdy", o_rdy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_data", o_data, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_reset", o_rdy, 1);
    for (int i = 0; i < 12; i++) begin
      send_bit(pat[i], n);
      if (i == 8) chk("busy_cycles", n, D + 1);
    end
    drain();
    chk("directed_blocks", got.size(), 2);
    if (got.size() >= 2) begin
      chk("directed_blk0", got[0], 4'b1101);
      chk("directed_blk1", got[1], 4'b0100);
    end
    for (int i = 0; i < 5 * BL; i++) send_bit(int'($urandom_range(0, 1)), n);
    drain();
    ideal = 1'b0;
    for (int i = 0; i < 6 * BL; i++) begin
      send_rand();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    left = (first_m ? D : BL) - fresh_m;
    for (int i = 0; i < left; i++) send_rand();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midtrace_rst_done", o_done, 0);
    chk("midtrace_rst_data", o_data, 0);
    chk("midtrace_rst_rdy", o_rdy, 0);
    sb.delete(); hist.delete(); bits.delete();
    fresh_m = 0; first_m = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < D - 1; i++) send_rand();
    @(negedge clk);
    chk("no_early_trigger", o_rdy, 1);
    send_rand();
    drain();
`ifdef TB_TERM_EN
    left = (first_m ? D : BL) - fresh_m;
    for (int i = 0; i < left - 1; i++) send_rand();
    send(NS'($urandom), 2'd3, 1'b1, n);
    for (int i = 0; i < D; i++) send_rand();
    drain();
`endif
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
